// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer for the arithmetic datapath: single-step, ALU and ones-count scan paths.
// Optional ALU_TIMEOUT_EN macro adds a WAIT/SWAIT watchdog that aborts to ILL after TIMEOUT cycles.
module alu_op_sequencer #(
    parameter  int unsigned NREG    = 16,
    parameter  int unsigned TIMEOUT = 15,
    localparam int unsigned IW      = 16,
    localparam int unsigned AW      = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    output logic [AW-1:0] rf_raddr,
    output logic          a_ld,
    output logic          b_ld,
    output logic [3:0]    alu_op,
    output logic          alu_start,
    input  logic          alu_done,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          step_en,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic          wb_sel,
    output logic          busy,
    output logic          done,
    output logic          illegal
);

    localparam logic [3:0] OP_ALU_LO = 4'd4;
    localparam logic [3:0] OP_ONES   = 4'd10;

    if (NREG == 0 || NREG > 16 || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
        $error("NREG must be a power of two no larger than 16");
    end
    if (TIMEOUT == 0 || TIMEOUT > 15) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..15");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_STEP, S_RDA, S_RDB, S_EXEC, S_WAIT, S_WB,
        S_SCLR, S_SRD, S_SEX, S_SWAIT, S_SACC, S_ILL
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [AW-1:0] idx_q, idx_d;

`ifdef ALU_TIMEOUT_EN
    localparam int unsigned CW = 4;
    logic [CW-1:0] tmo_q, tmo_d;
`endif

    logic          instr_ready_d, a_ld_d, b_ld_d, alu_start_d, acc_clr_d, acc_en_d;
    logic          step_en_d, rf_we_d, wb_sel_d, busy_d, done_d, illegal_d;
    logic [AW-1:0] rf_raddr_d;

    // Next-state, instruction capture and scan index
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        idx_d   = idx_q;
`ifdef ALU_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d = instr;
                    if (instr[15:12] < OP_ALU_LO) begin
                        state_d = S_STEP;
                    end else if (instr[15:12] < OP_ONES) begin
                        state_d = S_RDA;
                    end else if (instr[15:12] == OP_ONES) begin
                        state_d = S_SCLR;
                        idx_d   = '0;
                    end else begin
                        state_d = S_ILL;
                    end
                end
            end
            S_STEP: state_d = S_IDLE;
            S_RDA:  state_d = S_RDB;
            S_RDB:  state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_WAIT;
`ifdef ALU_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                if (alu_done) begin
                    state_d = S_WB;
`ifdef ALU_TIMEOUT_EN
                end else if (tmo_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ILL;
                end else begin
                    tmo_d = tmo_q + CW'(1);
`endif
                end
            end
            S_WB:   state_d = S_IDLE;
            S_SCLR: state_d = S_SRD;
            S_SRD:  state_d = S_SEX;
            S_SEX: begin
                state_d = S_SWAIT;
`ifdef ALU_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_SWAIT: begin
                if (alu_done) begin
                    state_d = S_SACC;
`ifdef ALU_TIMEOUT_EN
                end else if (tmo_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ILL;
                end else begin
                    tmo_d = tmo_q + CW'(1);
`endif
                end
            end
            S_SACC: begin
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = S_WB;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_SRD;
                end
            end
            S_ILL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore decode of the upcoming state so every control output leaves a flop
    always_comb begin
        instr_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        rf_raddr_d    = '0;
        a_ld_d        = 1'b0;
        b_ld_d        = 1'b0;
        alu_start_d   = 1'b0;
        acc_clr_d     = 1'b0;
        acc_en_d      = 1'b0;
        step_en_d     = 1'b0;
        rf_we_d       = 1'b0;
        wb_sel_d      = 1'b0;
        done_d        = 1'b0;
        illegal_d     = 1'b0;
        case (state_d)
            S_STEP: begin
                step_en_d = 1'b1;
                done_d    = 1'b1;
            end
            S_RDA: begin
                rf_raddr_d = ir_d[7:4];
                a_ld_d     = 1'b1;
            end
            S_RDB: begin
                rf_raddr_d = ir_d[3:0];
                b_ld_d     = 1'b1;
            end
            S_EXEC, S_SEX: alu_start_d = 1'b1;
            S_WB: begin
                rf_we_d  = 1'b1;
                done_d   = 1'b1;
                wb_sel_d = (ir_d[15:12] == OP_ONES);
            end
            S_SCLR: acc_clr_d = 1'b1;
            S_SRD: begin
                rf_raddr_d = idx_d;
                a_ld_d     = 1'b1;
            end
            S_SACC:  acc_en_d  = 1'b1;
            S_ILL:   illegal_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            idx_q       <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            rf_raddr    <= '0;
            a_ld        <= 1'b0;
            b_ld        <= 1'b0;
            alu_start   <= 1'b0;
            acc_clr     <= 1'b0;
            acc_en      <= 1'b0;
            step_en     <= 1'b0;
            rf_we       <= 1'b0;
            wb_sel      <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            idx_q       <= idx_d;
            instr_ready <= instr_ready_d;
            busy        <= busy_d;
            rf_raddr    <= rf_raddr_d;
            a_ld        <= a_ld_d;
            b_ld        <= b_ld_d;
            alu_start   <= alu_start_d;
            acc_clr     <= acc_clr_d;
            acc_en      <= acc_en_d;
            step_en     <= step_en_d;
            rf_we       <= rf_we_d;
            wb_sel      <= wb_sel_d;
            done        <= done_d;
            illegal     <= illegal_d;
        end
    end

`ifdef ALU_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Held instruction fields stay stable from acceptance until the next one
    assign rf_waddr = ir_q[11:8];
    assign alu_op   = ir_q[15:12];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; expected control words are hand-derived per cycle.
// Timeout expectations follow ALU_TIMEOUT_EN when that macro is defined.
module tb_alu_op_sequencer;

    logic        clk;
    logic        resetn;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  rf_raddr;
    logic        a_ld, b_ld, alu_start, alu_done, acc_clr, acc_en, step_en;
    logic        rf_we, wb_sel, busy, done, illegal;
    logic [3:0]  alu_op;
    logic [3:0]  rf_waddr;

    int n_cmp = 0;
    int n_err = 0;

    // Control word bit positions
    localparam logic [15:0] RDY = 16'h0800;
    localparam logic [15:0] ALD = 16'h0400;
    localparam logic [15:0] BLD = 16'h0200;
    localparam logic [15:0] AST = 16'h0100;
    localparam logic [15:0] CLR = 16'h0080;
    localparam logic [15:0] AEN = 16'h0040;
    localparam logic [15:0] STP = 16'h0020;
    localparam logic [15:0] WE  = 16'h0010;
    localparam logic [15:0] WSL = 16'h0008;
    localparam logic [15:0] BSY = 16'h0004;
    localparam logic [15:0] DN  = 16'h0002;
    localparam logic [15:0] ILL = 16'h0001;

    logic [15:0] ctrl;
    assign ctrl = {4'h0, instr_ready, a_ld, b_ld, alu_start, acc_clr, acc_en,
                   step_en, rf_we, wb_sel, busy, done, illegal};

    alu_op_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr    (rf_raddr),
        .a_ld        (a_ld),
        .b_ld        (b_ld),
        .alu_op      (alu_op),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .step_en     (step_en),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .wb_sel      (wb_sel),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn      = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        alu_done    = 1'b0;
        tick();
        tick();
        chk("reset_ctrl", ctrl, RDY);
        chk("reset_raddr", 16'(rf_raddr), 16'h0);
        chk("reset_waddr", 16'(rf_waddr), 16'h0);
        chk("reset_op", 16'(alu_op), 16'h0);
        resetn = 1'b1;
        tick();
        chk("idle_ctrl", ctrl, RDY);

        // Single-step opcode 2
        instr = 16'h2300; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("step_ctrl", ctrl, BSY | STP | DN);
        chk("step_op", 16'(alu_op), 16'h2);
        chk("step_waddr", 16'(rf_waddr), 16'h3);
        tick();
        chk("step_ret", ctrl, RDY);

        // ALU path; busy-time valid must be ignored, early alu_done ignored
        instr = 16'h4312; instr_valid = 1'b1;
        tick();
        instr = 16'h0000;
        chk("alu_rda", ctrl, BSY | ALD);
        chk("alu_rda_addr", 16'(rf_raddr), 16'h1);
        tick();
        chk("alu_rdb", ctrl, BSY | BLD);
        chk("alu_rdb_addr", 16'(rf_raddr), 16'h2);
        alu_done = 1'b1;
        tick();
        chk("alu_exec", ctrl, BSY | AST);
        tick();
        alu_done = 1'b0;
        chk("alu_wait1", ctrl, BSY);
        tick();
        chk("alu_wait2", ctrl, BSY);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        instr_valid = 1'b0;
        chk("alu_wb", ctrl, BSY | WE | DN);
        chk("alu_wb_addr", 16'(rf_waddr), 16'h3);
        chk("alu_wb_op", 16'(alu_op), 16'h4);
        tick();
        chk("alu_ret", ctrl, RDY);

        // ONESALL scan with immediate alu_done
        instr = 16'hA500; instr_valid = 1'b1; alu_done = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("scan_clr", ctrl, BSY | CLR);
        chk("scan_op", 16'(alu_op), 16'hA);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("scan_rd", ctrl, BSY | ALD);
            chk("scan_rd_addr", 16'(rf_raddr), 16'(i));
            tick();
            chk("scan_ex", ctrl, BSY | AST);
            tick();
            chk("scan_wait", ctrl, BSY);
            tick();
            chk("scan_acc", ctrl, BSY | AEN);
        end
        tick();
        alu_done = 1'b0;
        chk("scan_wb", ctrl, BSY | WE | WSL | DN);
        chk("scan_wb_addr", 16'(rf_waddr), 16'h5);
        tick();
        chk("scan_ret", ctrl, RDY);

        // Illegal opcode
        instr = 16'hC000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("ill_pulse", ctrl, BSY | ILL);
        tick();
        chk("ill_ret", ctrl, RDY);

        // Back-to-back: valid held through STEP, next accepted after return to IDLE
        instr = 16'h1000; instr_valid = 1'b1;
        tick();
        instr = 16'h0ABC;
        chk("b2b_step1", ctrl, BSY | STP | DN);
        chk("b2b_op1", 16'(alu_op), 16'h1);
        tick();
        chk("b2b_idle", ctrl, RDY);
        tick();
        instr_valid = 1'b0;
        chk("b2b_step2", ctrl, BSY | STP | DN);
        chk("b2b_op2", 16'(alu_op), 16'h0);
        chk("b2b_waddr2", 16'(rf_waddr), 16'hA);
        tick();

        // Reset during WAIT of 0x6123
        instr = 16'h6123; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_wait", ctrl, BSY);
        resetn = 1'b0;
        #1;
        chk("rst_async", ctrl, RDY);
        chk("rst_waddr", 16'(rf_waddr), 16'h0);
        chk("rst_op", 16'(alu_op), 16'h0);
        tick();
        resetn = 1'b1;
        alu_done = 1'b1;
        tick();
        chk("rst_after1", ctrl, RDY);
        tick();
        alu_done = 1'b0;
        chk("rst_after2", ctrl, RDY);

        // ALU_TIMEOUT_EN: WAIT held without alu_done
        instr = 16'h7123; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        chk("tmo_exec", ctrl, BSY | AST);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("tmo_wait", ctrl, BSY);
        end
        tick();
`ifdef ALU_TIMEOUT_EN
        chk("tmo_ill", ctrl, BSY | ILL);
        tick();
        chk("tmo_ret", ctrl, RDY);
`else
        for (int k = 0; k < 10; k++) begin
            chk("tmo_hold", ctrl, BSY);
            tick();
        end
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("tmo_wb", ctrl, BSY | WE | DN);
        tick();
        chk("tmo_ret", ctrl, RDY);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
